// File: rtl/crypt_seq_pkg.sv
// Shared types and default sizing for the FIFO-to-crypto-core block sequencer.
package crypt_seq_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int CNT_WIDTH       = 16;
  localparam int BLOCK_WIDTH     = DATA_WIDTH * WORDS_PER_BLOCK;
  localparam int WCNT_WIDTH      = $clog2(WORDS_PER_BLOCK + 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    WAIT,
    DRAIN
  } state_t;

endpackage

// File: rtl/seq_word_packer.sv
// Issues FIFO reads, captures the registered read data one cycle later and
// packs the words into a block, word 0 in the LSBs.
module seq_word_packer
  import crypt_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = crypt_seq_pkg::DATA_WIDTH,
  parameter int WORDS_PER_BLOCK = crypt_seq_pkg::WORDS_PER_BLOCK
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  fill_en,
  input  logic                                  clear,
  input  logic                                  fifo_empty,
  input  logic [DATA_WIDTH-1:0]                 fifo_data,
  output logic                                  fifo_r_en,
  output logic                                  fill_done,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] core_block
);

  localparam int WCW = $clog2(WORDS_PER_BLOCK + 1);

  logic [WCW-1:0] issued_reg;
  logic [WCW-1:0] captured_reg;
  logic           rd_pending_reg;

  assign fifo_r_en = fill_en && (issued_reg < WCW'(WORDS_PER_BLOCK)) && !fifo_empty;
  // Fires on the capture of the last word so the FSM leaves FILL without an extra cycle.
  assign fill_done = rd_pending_reg && (captured_reg == WCW'(WORDS_PER_BLOCK - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      issued_reg     <= '0;
      captured_reg   <= '0;
      rd_pending_reg <= 1'b0;
    end else begin
      rd_pending_reg <= fifo_r_en;
      if (fifo_r_en) begin
        issued_reg <= issued_reg + 1'b1;
      end
      if (rd_pending_reg) begin
        captured_reg <= captured_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (rd_pending_reg && (captured_reg == WCW'(gi))) begin
          word_reg <= fifo_data;
        end
      end

      assign core_block[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/fifo_block_sequencer.sv
// Gathers FIFO words into cipher blocks, runs them through the crypto core
// with a start/done handshake and streams the results out on valid/ready.
module fifo_block_sequencer
  import crypt_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = crypt_seq_pkg::DATA_WIDTH,
  parameter int WORDS_PER_BLOCK = crypt_seq_pkg::WORDS_PER_BLOCK,
  parameter int CNT_WIDTH       = crypt_seq_pkg::CNT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  input  logic                                  fifo_empty,
  output logic                                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0]                 fifo_data,
  output logic                                  core_start,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] core_block,
  input  logic                                  core_done,
  input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] core_result,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] out_data,
  output logic                                  busy,
  output logic [CNT_WIDTH-1:0]                  blocks_done
);

  localparam int BLK_W = DATA_WIDTH * WORDS_PER_BLOCK;

  state_t             state_reg;
  state_t             state_next;
  logic [BLK_W-1:0]   out_data_reg;
  logic [CNT_WIDTH-1:0] blocks_done_reg;
  logic               fill_done;
  logic               handshake;

  assign handshake = (state_reg == DRAIN) && out_ready;

  seq_word_packer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_en    (state_reg == FILL),
    .clear      (handshake),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .fill_done  (fill_done),
    .core_block (core_block)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (enable) state_next = FILL;
      end
      FILL: begin
        if (fill_done) state_next = START;
      end
      START: begin
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (core_done) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) state_next = enable ? FILL : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A done pulse is only meaningful while the core owns the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg    <= '0;
      blocks_done_reg <= '0;
    end else begin
      if ((state_reg == WAIT) && core_done) begin
        out_data_reg <= core_result;
      end
      if (handshake) begin
        blocks_done_reg <= blocks_done_reg + 1'b1;
      end
    end
  end

  assign out_data    = out_data_reg;
  assign blocks_done = blocks_done_reg;

endmodule

// File: tb/tb_fifo_block_sequencer.sv
// Randomized self-checking bench: FIFO and core models plus a word-queue reference.
module tb_fifo_block_sequencer;

  localparam int DW  = 32;
  localparam int WPB = 4;
  localparam int BW  = DW * WPB;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data = '0;
  logic          core_start;
  logic [BW-1:0] core_block;
  logic          core_done = 1'b0;
  logic [BW-1:0] core_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          busy;
  logic [CW-1:0] blocks_done;

  int errors = 0;
  int checks = 0;

  fifo_block_sequencer #(
    .DATA_WIDTH      (DW),
    .WORDS_PER_BLOCK (WPB),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_r_en   (fifo_r_en),
    .fifo_data   (fifo_data),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .blocks_done (blocks_done)
  );

  always #5 clk = ~clk;

  // FIFO contents and the reference word stream
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] ref_q[$];
  logic [BW-1:0] start_q[$];
  logic [BW-1:0] out_q[$];
  int            rd_cyc_q[$];
  int cyc = 0, rd_cnt = 0, viol_cnt = 0, start_cyc = 0, last_rd_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_en) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
      rd_cyc_q.push_back(cyc);
      if (fifo_empty) viol_cnt <= viol_cnt + 1;
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    end
    if (core_start) begin
      start_q.push_back(core_block);
      start_cyc <= cyc;
    end
    if (out_valid && out_ready) out_q.push_back(out_data);
  end

  always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

  // Core model: result = ~block, done core_delay cycles after start (core_delay >= 2)
  int            core_delay = 5;
  int            core_cnt = 0;
  logic [BW-1:0] core_res = '0;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      core_cnt <= core_delay - 1;
      core_res <= ~core_block;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_done   <= 1'b1;
        core_result <= core_res;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(w);
  endtask

  function automatic logic [BW-1:0] next_ref_block();
    logic [BW-1:0] b = '0;
    for (int k = 0; k < WPB; k++) b[k*DW +: DW] = ref_q.pop_front();
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    fifo_q.delete(); ref_q.delete(); start_q.delete(); out_q.delete(); rd_cyc_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && out_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got=%b exp=0", fifo_r_en); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", core_start); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (blocks_done !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", blocks_done); end
    checks++; if (out_data !== '0 || core_block !== '0) begin errors++; $display("FAIL reset_data out=%h blk=%h exp=0", out_data, core_block); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int e0;
    do_reset();
    core_delay = 5;
    push_word(32'h11111111); push_word(32'h22222222); push_word(32'h33333333); push_word(32'h44444444);
    @(negedge clk);
    enable = 1'b1; e0 = cyc;
    @(negedge clk);
    enable = 1'b0;
    wait_out(1, 100);
    checks++;
    if (out_q.size() != 1 || start_q.size() != 1) begin
      errors++; $display("FAIL basic_timeout outs=%0d starts=%0d exp=1", out_q.size(), start_q.size());
    end else begin
      logic [BW-1:0] sb, ob;
      sb = start_q.pop_front(); ob = out_q.pop_front();
      checks++; if (sb !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_block got=%h", sb); end
      checks++; if (ob !== 128'hBBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE) begin errors++; $display("FAIL basic_out got=%h", ob); end
      checks++; if (start_cyc - e0 != 6) begin errors++; $display("FAIL basic_latency got=%0d exp=6", start_cyc - e0); end
    end
    @(negedge clk);
    checks++; if (blocks_done !== 16'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", blocks_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle busy=%b exp=0", busy); end
    $display("test_basic done latency=%0d", start_cyc - e0);
  endtask

  task automatic test_empty_stall();
    int r0, v0;
    logic [BW-1:0] eb;
    do_reset();
    core_delay = $urandom_range(2, 6);
    r0 = rd_cnt; v0 = viol_cnt;
    push_word($urandom()); push_word($urandom());
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (start_q.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL stall_early starts=%0d busy=%b exp=0/1", start_q.size(), busy); end
    push_word($urandom()); push_word($urandom());
    wait_out(1, 100);
    eb = next_ref_block();
    checks++;
    if (out_q.size() != 1 || start_q.size() != 1) begin
      errors++; $display("FAIL stall_timeout outs=%0d exp=1", out_q.size());
    end else begin
      logic [BW-1:0] sb, ob;
      sb = start_q.pop_front(); ob = out_q.pop_front();
      checks++; if (sb !== eb) begin errors++; $display("FAIL stall_block got=%h exp=%h", sb, eb); end
      checks++; if (ob !== ~eb) begin errors++; $display("FAIL stall_out got=%h exp=%h", ob, ~eb); end
      checks++; if (start_cyc != last_rd_cyc + 2) begin errors++; $display("FAIL stall_start_cyc got=%0d exp=%0d", start_cyc, last_rd_cyc + 2); end
    end
    checks++; if (rd_cnt - r0 != 4) begin errors++; $display("FAIL stall_reads got=%0d exp=4", rd_cnt - r0); end
    checks++; if (viol_cnt != v0) begin errors++; $display("FAIL stall_read_empty got=%0d exp=0", viol_cnt - v0); end
    $display("test_empty_stall done reads=%0d", rd_cnt - r0);
  endtask

  task automatic test_backpressure();
    int r0;
    logic [BW-1:0] eb, held;
    do_reset();
    core_delay = $urandom_range(2, 6);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) push_word($urandom());
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 100 && out_valid !== 1'b1; i++) @(negedge clk);
    eb = next_ref_block();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout valid=%b exp=1", out_valid); end
    checks++; if (out_data !== ~eb) begin errors++; $display("FAIL bp_data got=%h exp=%h", out_data, ~eb); end
    held = out_data; r0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || blocks_done !== 16'd0) begin
        errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h count=%0d", i, out_valid, out_data, blocks_done);
      end
    end
    checks++; if (rd_cnt != r0) begin errors++; $display("FAIL bp_reads got=%0d exp=0", rd_cnt - r0); end
    out_ready = 1'b1; enable = 1'b0;
    @(negedge clk);
    checks++; if (blocks_done !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release count=%0d valid=%b exp=1/0", blocks_done, out_valid); end
    checks++; if (out_q.size() != 1 || rd_cnt != r0) begin errors++; $display("FAIL bp_accept outs=%0d reads=%0d exp=1/0", out_q.size(), rd_cnt - r0); end
    $display("test_backpressure done count=%0d", blocks_done);
  endtask

  task automatic test_enable_drop();
    int r0;
    logic [BW-1:0] eb;
    do_reset();
    core_delay = $urandom_range(2, 6);
    r0 = rd_cnt;
    for (int k = 0; k < 12; k++) push_word($urandom());
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_out(1, 100);
    eb = next_ref_block();
    checks++;
    if (out_q.size() != 1) begin
      errors++; $display("FAIL drop_timeout outs=%0d exp=1", out_q.size());
    end else begin
      logic [BW-1:0] ob;
      ob = out_q.pop_front();
      checks++; if (ob !== ~eb) begin errors++; $display("FAIL drop_out got=%h exp=%h", ob, ~eb); end
    end
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", busy); end
    checks++; if (rd_cnt - r0 != 4 || fifo_q.size() != 8) begin errors++; $display("FAIL drop_reads got=%0d left=%0d exp=4/8", rd_cnt - r0, fifo_q.size()); end
    checks++; if (blocks_done !== 16'd1) begin errors++; $display("FAIL drop_count got=%0d exp=1", blocks_done); end
    $display("test_enable_drop done reads=%0d", rd_cnt - r0);
  endtask

  task automatic test_reset_wait();
    do_reset();
    core_delay = 8;
    for (int k = 0; k < 4; k++) push_word($urandom());
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 100 && start_q.size() == 0; i++) @(negedge clk);
    checks++; if (start_q.size() != 1) begin errors++; $display("FAIL rstw_timeout starts=%0d exp=1", start_q.size()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0 || fifo_r_en !== 1'b0 || core_block !== '0 || out_data !== '0) begin
      errors++; $display("FAIL rstw_outputs busy=%b valid=%b start=%b ren=%b blk=%h out=%h", busy, out_valid, core_start, fifo_r_en, core_block, out_data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || blocks_done !== '0 || out_data !== '0) begin
        errors++; $display("FAIL rstw_late_done cyc=%0d busy=%b valid=%b count=%0d out=%h", i, busy, out_valid, blocks_done, out_data);
      end
    end
    $display("test_reset_wait done busy=%b", busy);
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 64; k++) push_word($urandom());
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 3000 && out_q.size() < 16; i++) begin
      core_delay = $urandom_range(2, 6);
      @(negedge clk);
    end
    checks++;
    if (out_q.size() != 16 || start_q.size() != 16 || rd_cyc_q.size() != 64) begin
      errors++; $display("FAIL stream_timeout outs=%0d starts=%0d reads=%0d exp=16/16/64", out_q.size(), start_q.size(), rd_cyc_q.size());
    end else begin
      for (int b = 0; b < 16; b++) begin
        logic [BW-1:0] eb, sb, ob;
        int base;
        eb = next_ref_block(); sb = start_q.pop_front(); ob = out_q.pop_front();
        checks++;
        if (sb !== eb || ob !== ~eb) begin errors++; $display("FAIL stream_block%0d blk=%h out=%h exp=%h", b, sb, ob, eb); end
        base = rd_cyc_q.pop_front();
        for (int k = 1; k < WPB; k++) begin
          int rc;
          rc = rd_cyc_q.pop_front();
          checks++;
          if (rc != base + k) begin errors++; $display("FAIL stream_rate blk=%0d word=%0d cyc=%0d exp=%0d", b, k, rc, base + k); end
        end
      end
    end
    checks++; if (blocks_done !== 16'd16) begin errors++; $display("FAIL stream_count got=%0d exp=16", blocks_done); end
    enable = 1'b0;
    $display("test_stream done count=%0d", blocks_done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_stall();
    test_backpressure();
    test_enable_drop();
    test_reset_wait();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
